// File: rtl/axil_arbiter_rr_wr.sv
`default_nettype none
// ============================================================================
//  Module   : axil_arbiter_rr_wr
//  Purpose  : Round-robin write-channel arbiter for one AXI-Lite slave port.
//             Grants one master for a complete AW + W + B transaction, then
//             rotates priority past the master that was just served. A
//             watchdog forces a release if a granted transaction stalls.
//  Ports    : aclk, areset            - clock, synchronous active-high reset
//             request_wr              - per-master write requests
//             s_axil_aw/w/b valid/ready - handshakes observed on the slave side
//             grant_wr                - one-hot grant (zero when idle)
//             grant_wr_cdr            - binary index of the granted master
//             grant_valid             - high while a grant is held
//             timeout_err             - one-cycle pulse on watchdog release
//  Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter_rr_wr #(
    parameter int NUMBER_MASTER  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUMBER_MASTER-1:0] request_wr,
    input  logic                     s_axil_awvalid,
    input  logic                     s_axil_awready,
    input  logic                     s_axil_wvalid,
    input  logic                     s_axil_wready,
    input  logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    output logic [NUMBER_MASTER-1:0] grant_wr,
    output logic [((NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1)-1:0] grant_wr_cdr,
    output logic                     grant_valid,
    output logic                     timeout_err
);

    localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] C_LAST_RESET = IDX_W'(NUMBER_MASTER - 1);
    localparam bit C_WD_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t             state_q;
    logic               aw_done_q;
    logic               w_done_q;
    logic [CNT_W-1:0]   wd_cnt_q;
    logic [IDX_W-1:0]   last_ptr_q;

    logic                     sel_found_d;
    logic [IDX_W-1:0]         sel_idx_d;
    logic [NUMBER_MASTER-1:0] sel_onehot_d;
    logic [NUMBER_MASTER-1:0] req_rot;
    logic [NUMBER_MASTER-1:0] one_hot_base;
    int                       cand;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic wd_expired;

    assign aw_hs      = s_axil_awvalid & s_axil_awready;
    assign w_hs       = s_axil_wvalid  & s_axil_wready;
    assign b_hs       = s_axil_bvalid  & s_axil_bready;
    assign wd_expired = C_WD_EN && (wd_cnt_q == C_CNT_LIMIT);

    // Round-robin pick: scan candidates from farthest to nearest after
    // last_ptr so that the final hit is the highest-priority requester.
    always_comb begin
        sel_found_d     = 1'b0;
        sel_idx_d       = '0;
        sel_onehot_d    = '0;
        req_rot         = '0;
        cand            = 0;
        one_hot_base    = '0;
        one_hot_base[0] = 1'b1;
        for (int i = NUMBER_MASTER; i >= 1; i--) begin
            cand    = (int'(last_ptr_q) + i) % NUMBER_MASTER;
            req_rot = request_wr >> cand;
            if (req_rot[0]) begin
                sel_found_d  = 1'b1;
                sel_idx_d    = IDX_W'(cand);
                sel_onehot_d = one_hot_base << cand;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            grant_wr     <= '0;
            grant_wr_cdr <= '0;
            grant_valid  <= 1'b0;
            timeout_err  <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            wd_cnt_q     <= '0;
            last_ptr_q   <= C_LAST_RESET;
        end else begin
            timeout_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_found_d) begin
                        grant_wr     <= sel_onehot_d;
                        grant_wr_cdr <= sel_idx_d;
                        grant_valid  <= 1'b1;
                        wd_cnt_q     <= '0;
                        state_q      <= S_DATA;
                    end
                end
                S_DATA: begin
                    // A B handshake here is meaningless and deliberately ignored.
                    if (wd_expired) begin
                        timeout_err <= 1'b1;
                        grant_wr    <= '0;
                        grant_valid <= 1'b0;
                        state_q     <= S_REL;
                    end else begin
                        aw_done_q <= aw_done_q | aw_hs;
                        w_done_q  <= w_done_q  | w_hs;
                        wd_cnt_q  <= wd_cnt_q + CNT_W'(1);
                        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // B completion takes priority over a simultaneous expiry.
                    if (b_hs) begin
                        grant_wr    <= '0;
                        grant_valid <= 1'b0;
                        state_q     <= S_REL;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        grant_wr    <= '0;
                        grant_valid <= 1'b0;
                        state_q     <= S_REL;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                end
                S_REL: begin
                    last_ptr_q <= grant_wr_cdr;
                    aw_done_q  <= 1'b0;
                    w_done_q   <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_rr_wr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_arbiter_rr_wr
//  Purpose  : Self-checking bench for axil_arbiter_rr_wr (4-master instance
//             with an 8-cycle watchdog, plus a 1-master instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter_rr_wr;

    localparam int NM = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NM-1:0] request_wr = '0;
    logic          awvalid = 1'b0, awready = 1'b0;
    logic          wvalid = 1'b0, wready = 1'b0;
    logic          bvalid = 1'b0, bready = 1'b0;
    logic [NM-1:0] grant_wr;
    logic [1:0]    grant_wr_cdr;
    logic          grant_valid;
    logic          timeout_err;

    logic          r1_req = 1'b0;
    logic          r1_aw = 1'b0, r1_w = 1'b0, r1_b = 1'b0;
    logic [0:0]    g1_grant;
    logic [0:0]    g1_cdr;
    logic          g1_valid;
    logic          g1_to;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last_ptr;   // reference model: index served most recently

    always #5 clk = ~clk;

    axil_arbiter_rr_wr #(.NUMBER_MASTER(NM), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(clk), .areset(rst), .request_wr(request_wr),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .grant_wr(grant_wr), .grant_wr_cdr(grant_wr_cdr),
        .grant_valid(grant_valid), .timeout_err(timeout_err)
    );

    axil_arbiter_rr_wr #(.NUMBER_MASTER(1), .TIMEOUT_CYCLES(TO)) dut1 (
        .aclk(clk), .areset(rst), .request_wr(r1_req),
        .s_axil_awvalid(r1_aw), .s_axil_awready(r1_aw),
        .s_axil_wvalid(r1_w), .s_axil_wready(r1_w),
        .s_axil_bvalid(r1_b), .s_axil_bready(r1_b),
        .grant_wr(g1_grant), .grant_wr_cdr(g1_cdr),
        .grant_valid(g1_valid), .timeout_err(g1_to)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a valid/ready pair: full handshake when hs, otherwise a random
    // non-handshake pattern (00, 01 or 10).
    task automatic drive_pair(input bit hs, output logic v, output logic r);
        int sel;
        sel = $urandom_range(0, 2);
        if (hs) begin
            v = 1'b1; r = 1'b1;
        end else begin
            v = (sel == 1); r = (sel == 2);
        end
    endtask

    // One complete arbitration round on the 4-master instance. Called with
    // the DUT in IDLE; returns with the DUT in IDLE again. Cycle k counts
    // from the first cycle the grant is visible; -1 means "never".
    task automatic do_txn(input logic [NM-1:0] req, input logic [NM-1:0] req_mid,
                          input int aw_c, input int w_c, input int b_c, input string tag);
        int          exp_idx;
        int          both;
        int          r;
        bit          b_ok;
        logic [NM-1:0] exp_oh;
        logic [1:0]  exp_cdr;
        exp_idx = -1;
        for (int i = 1; i <= NM; i++) begin
            int k;
            k = (m_last_ptr + i) % NM;
            if (req[k] && exp_idx < 0) exp_idx = k;
        end
        exp_oh  = 4'b0001 << exp_idx;
        exp_cdr = exp_idx[1:0];
        both = (aw_c >= 0 && w_c >= 0) ? ((aw_c > w_c) ? aw_c : w_c) : 1000;
        b_ok = (b_c >= 0) && (b_c > both) && (b_c <= TO - 1);
        r    = b_ok ? b_c : TO - 1;

        request_wr = req;
        tick();
        for (int k = 0; k <= r; k++) begin
            if (k == 1) request_wr = req_mid;
            drive_pair(k == aw_c, awvalid, awready);
            drive_pair(k == w_c,  wvalid,  wready);
            drive_pair(k == b_c,  bvalid,  bready);
            n_checks++;
            if (grant_wr !== exp_oh || grant_valid !== 1'b1 || grant_wr_cdr !== exp_cdr || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s held k=%0d: grant=%b cdr=%0d valid=%b to=%b, want grant=%b cdr=%0d valid=1 to=0",
                         tag, k, grant_wr, grant_wr_cdr, grant_valid, timeout_err, exp_oh, exp_cdr);
            end
            tick();
        end
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
        n_checks++;
        if (grant_wr !== '0 || grant_valid !== 1'b0 || timeout_err !== !b_ok || grant_wr_cdr !== exp_cdr) begin
            n_fail++;
            $display("FAIL %s release: grant=%b valid=%b to=%b cdr=%0d, want grant=0 valid=0 to=%b cdr=%0d",
                     tag, grant_wr, grant_valid, timeout_err, grant_wr_cdr, !b_ok, exp_cdr);
        end
        tick();
        n_checks++;
        if (grant_wr !== '0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle gap: grant=%b valid=%b to=%b, want all 0",
                     tag, grant_wr, grant_valid, timeout_err);
        end
        m_last_ptr = exp_idx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        request_wr = 4'b1111;
        tick(); tick();
        n_checks++;
        if (grant_wr !== '0 || grant_wr_cdr !== '0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b cdr=%0d valid=%b to=%b, want all 0",
                     grant_wr, grant_wr_cdr, grant_valid, timeout_err);
        end
        rst = 1'b0;
        request_wr = '0;
        m_last_ptr = NM - 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (grant_wr !== '0 || grant_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_req: grant=%b valid=%b, want 0 0", grant_wr, grant_valid);
            end
        end
    endtask

    task automatic test_rr_all();
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 4'b1111, 0, 0, 2, "rr_all");
    endtask

    task automatic test_split_phases();
        do_txn(4'b0100, 4'b0100, 2, 5, 7, "split_phases");
        // last_ptr is now 2: with everyone requesting, master 3 is next.
        do_txn(4'b1111, 4'b1111, 1, 0, 2, "after_split");
    endtask

    task automatic test_req_change();
        do_txn(4'b0010, 4'b1001, 0, 0, 2, "req_change_hold");
        do_txn(4'b1001, 4'b1001, 0, 1, 3, "req_change_next");
    endtask

    task automatic test_timeout();
        do_txn(4'b0001, 4'b0001, 0, -1, -1, "timeout_no_w");
        do_txn(4'b0011, 4'b0011, 0, 0, 7, "b_at_expiry");
        do_txn(4'b0110, 4'b0110, 1, 1, -1, "timeout_no_b");
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last_ptr = NM - 1;
        request_wr = 4'b1000;
        tick();
        n_checks++;
        if (grant_wr !== 4'b1000 || grant_wr_cdr !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_mid_grant: grant=%b cdr=%0d, want 1000 3", grant_wr, grant_wr_cdr);
        end
        awvalid = 1; awready = 1; wvalid = 1; wready = 1;
        tick();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (grant_wr !== '0 || grant_wr_cdr !== '0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: grant=%b cdr=%0d valid=%b to=%b, want all 0",
                     grant_wr, grant_wr_cdr, grant_valid, timeout_err);
        end
        rst = 1'b0;
        m_last_ptr = NM - 1;
        do_txn(4'b1001, 4'b1001, 0, 0, 1, "reset_mid_next");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [NM-1:0] req;
            logic [NM-1:0] mid;
            int aw_c, w_c, b_c, mx, sel;
            req = NM'($urandom_range(1, 15));
            mid = NM'($urandom_range(0, 15));
            aw_c = $urandom_range(0, 4);
            w_c  = $urandom_range(0, 4);
            mx   = (aw_c > w_c) ? aw_c : w_c;
            sel  = $urandom_range(0, 9);
            if (sel == 0)      w_c = -1;
            else if (sel == 1) aw_c = -1;
            if (sel == 2)      b_c = -1;
            else if (sel == 3) b_c = mx;
            else               b_c = mx + 1 + $urandom_range(0, 3);
            do_txn(req, mid, aw_c, w_c, b_c, "random");
        end
    endtask

    task automatic test_single_master();
        for (int i = 0; i < 3; i++) begin
            r1_req = 1'b1;
            tick();
            n_checks++;
            if (g1_grant !== 1'b1 || g1_cdr !== 1'b0 || g1_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_grant: grant=%b cdr=%b valid=%b, want 1 0 1", g1_grant, g1_cdr, g1_valid);
            end
            r1_aw = 1; r1_w = 1;
            tick();
            r1_aw = 0; r1_w = 0; r1_b = 1;
            tick();
            r1_b = 0;
            n_checks++;
            if (g1_grant !== 1'b0 || g1_valid !== 1'b0 || g1_to !== 1'b0 || g1_cdr !== 1'b0) begin
                n_fail++;
                $display("FAIL single_rel: grant=%b valid=%b to=%b cdr=%b, want 0 0 0 0", g1_grant, g1_valid, g1_to, g1_cdr);
            end
            tick();
            n_checks++;
            if (g1_grant !== 1'b0) begin
                n_fail++;
                $display("FAIL single_idle: grant=%b, want 0", g1_grant);
            end
        end
        r1_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "time limit");
    end

    initial begin
        m_last_ptr = NM - 1;
        test_reset();
        test_rr_all();
        test_split_phases();
        test_req_change();
        test_timeout();
        test_reset_mid();
        test_random();
        test_single_master();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
